reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file. Successor to the 2R1W integer register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional same-cycle write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight writers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 1, number of write ports.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the incoming write data; 0 = it returns the stored (old) value.
- ZERO_REG, 1: 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  output  NUM_RD  busy bit of the addressed register, per port.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  write addresses.
- wr_data  input  NUM_WR*DATA_W  write data.
- iss_en  input  1  issue strobe: mark iss_addr busy.
- iss_addr  input  ADDR_W  destination register of the issuing instruction.
- flush  input  1  synchronous clear of all busy bits; data is kept.
- wr_conflict  output  1  registered pulse: two or more enabled write ports targeted the same address in the previous cycle.

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers = 0; all busy bits = 0; wr_conflict = 0.
  - rd_data reads 0 and rd_busy reads 0 while rst is held.
- Write:
  - On posedge, for each port p with wr_en[p]=1, regs[wr_addr[p]] <= wr_data[p].
  - Writes to addr 0 are dropped when ZERO_REG=1.
  - Same-address collision among write ports: the highest-index port wins.
  - A collision on addr 0 with ZERO_REG=1 does not assert wr_conflict.
- wr_conflict: registered; high for exactly one cycle following the colliding cycle.
- Read: combinational, zero latency.
  - ZERO_REG=1 and rd_addr==0 -> rd_data = 0, rd_busy = 0.
  - BYPASS=1 and any enabled write port matches rd_addr (nonzero, or ZERO_REG=0) -> rd_data = wr_data of the highest-index matching port.
  - Otherwise rd_data = stored value.
  - With bypass, rd_busy reflects the post-update busy value for that address.
  - Without bypass, rd_busy reflects the stored busy bit.
- Scoreboard (one busy bit per register), updated on posedge, in priority order (first match applies):
  1. flush=1 -> all busy bits <= 0; iss_en in the same cycle is ignored.
  2. iss_en=1 -> busy[iss_addr] <= 1, even if a write to iss_addr lands the same cycle (the new producer owns the register).
  3. Any enabled write port to address a -> busy[a] <= 0.
- iss_en to addr 0 with ZERO_REG=1 is ignored.
- Writes to non-busy registers are legal and update data normally.
- Read-port count and write-port count are independent.
- No combinational path from rd_addr to any sequential state.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Width rules:
  - wr_data is stored unmodified.
  - Address decode is exact; the full 2**ADDR_W entries are implemented.

Test Plan:
- Reset, then read all addresses on every read port -> rd_data = 0 and rd_busy = 0 everywhere. Assert rst mid-stream after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately, before the next edge.
- Write 0xA5A5A5A5 to r3 on port 0; same cycle read r3 -> 0xA5A5A5A5 with BYPASS=1, old value 0 with BYPASS=0. Next cycle both configs read 0xA5A5A5A5.
- ZERO_REG=1: write 0x1234 to r0 and iss_en r0 -> r0 reads 0 and rd_busy=0. With ZERO_REG=0, r0 reads 0x1234.
- NUM_WR=2: ports 0 and 1 both write r7 (0x11, 0x22) -> r7 = 0x22 and wr_conflict=1 for one cycle. Different addresses -> both stored and wr_conflict stays 0.
- Scoreboard sequence:
  - iss r9 -> rd_busy=1 next cycle.
  - write r9 -> busy clears.
  - iss r9 and write r9 in the same cycle -> busy stays 1.
  - iss r10 with flush -> busy of all registers, r10 included, = 0.
- NUM_RD=4, ADDR_W=6, DATA_W=64: random writes checked against a reference array; all 4 ports read distinct addresses each cycle -> values match.

Source files
------------

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NUM_RD combinational read ports, NUM_WR write
// ports, optional write-to-read bypass, optional hardwired zero register, busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              conflict_d;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // Ascending port order: the last non-blocking assignment wins, so the highest port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && writable(wr_addr[p*ADDR_W +: ADDR_W]))
          regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // Priority: flush, then issue (overrides a same-cycle write), then write-back clears.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && writable(wr_addr[p*ADDR_W +: ADDR_W]))
          busy_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_en && writable(iss_addr)) busy_nxt[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (wr_en[p] && wr_en[q] &&
            wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[q*ADDR_W +: ADDR_W] &&
            writable(wr_addr[p*ADDR_W +: ADDR_W]))
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_d;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              b;
      ra = rd_addr[r*ADDR_W +: ADDR_W];
      d  = regs[ra];
      b  = (BYPASS != 0) ? busy_nxt[ra] : busy[ra];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra && writable(ra))
            d = wr_data[p*DATA_W +: DATA_W];
        end
      end
      // Outputs are forced quiet while reset is held, even if a bypass would hit.
      if (rst || !writable(ra)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[r*DATA_W +: DATA_W] = d;
      rd_busy[r] = b;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default bypass/zero-reg config with two write
// ports, a no-bypass/no-zero-reg config, and a wide 4-read-port config against a reference array.
module tb_reg_file_mp;

  logic clk, rst;
  int total, bad;

  logic [9:0]  m_rd_addr;  logic [63:0] m_rd_data;  logic [1:0] m_rd_busy;
  logic [1:0]  m_wr_en;    logic [9:0]  m_wr_addr;  logic [63:0] m_wr_data;
  logic        m_iss_en;   logic [4:0]  m_iss_addr; logic m_flush; logic m_conf;

  logic [9:0]  n_rd_addr;  logic [63:0] n_rd_data;  logic [1:0] n_rd_busy;
  logic [0:0]  n_wr_en;    logic [4:0]  n_wr_addr;  logic [31:0] n_wr_data;
  logic        n_iss_en;   logic [4:0]  n_iss_addr; logic n_flush; logic n_conf;

  logic [23:0]  w_rd_addr; logic [255:0] w_rd_data; logic [3:0] w_rd_busy;
  logic [1:0]   w_wr_en;   logic [11:0]  w_wr_addr; logic [127:0] w_wr_data;
  logic         w_iss_en;  logic [5:0]   w_iss_addr; logic w_flush; logic w_conf;

  reg_file_mp #(.NUM_WR(2)) u_main (
    .clk(clk), .rst(rst), .rd_addr(m_rd_addr), .rd_data(m_rd_data), .rd_busy(m_rd_busy),
    .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data), .iss_en(m_iss_en),
    .iss_addr(m_iss_addr), .flush(m_flush), .wr_conflict(m_conf));

  reg_file_mp #(.BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(n_rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data), .iss_en(n_iss_en),
    .iss_addr(n_iss_addr), .flush(n_flush), .wr_conflict(n_conf));

  reg_file_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .NUM_WR(2)) u_wide (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .iss_en(w_iss_en),
    .iss_addr(w_iss_addr), .flush(w_flush), .wr_conflict(w_conf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] m_rd(input int i);
    return m_rd_data[i*32 +: 32];
  endfunction

  function automatic logic [31:0] n_rd(input int i);
    return n_rd_data[i*32 +: 32];
  endfunction

  task automatic idle_all();
    m_wr_en = '0; m_iss_en = 1'b0; m_flush = 1'b0;
    n_wr_en = '0; n_iss_en = 1'b0; n_flush = 1'b0;
    w_wr_en = '0; w_iss_en = 1'b0; w_flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int a = 0; a < 32; a++) begin
      m_rd_addr = {5'(a), 5'(a)};
      n_rd_addr = {5'(a), 5'(a)};
      #1;
      for (int p = 0; p < 2; p++) begin
        total++; if (m_rd(p) !== 32'h0) begin bad++; $display("FAIL rst_m_data a=%0d p=%0d got=%h want=0", a, p, m_rd(p)); end
        total++; if (m_rd_busy[p] !== 1'b0) begin bad++; $display("FAIL rst_m_busy a=%0d p=%0d got=%b want=0", a, p, m_rd_busy[p]); end
        total++; if (n_rd(p) !== 32'h0) begin bad++; $display("FAIL rst_n_data a=%0d p=%0d got=%h want=0", a, p, n_rd(p)); end
        total++; if (n_rd_busy[p] !== 1'b0) begin bad++; $display("FAIL rst_n_busy a=%0d p=%0d got=%b want=0", a, p, n_rd_busy[p]); end
      end
    end
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL rst_conf got=%b want=0", m_conf); end
    @(negedge clk) rst = 1'b0;
    // Mid-stream asynchronous reset after a write to r5
    @(negedge clk);
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd5}; m_wr_data = {32'h0, 32'hDEADBEEF};
    @(negedge clk);
    m_wr_en = '0; m_rd_addr = {5'd0, 5'd5};
    #1;
    total++; if (m_rd(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_rst_r5 got=%h want=deadbeef", m_rd(0)); end
    #1 rst = 1'b1;
    #1;
    total++; if (m_rd(0) !== 32'h0) begin bad++; $display("FAIL async_rst_r5 got=%h want=0", m_rd(0)); end
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (m_rd(0) !== 32'h0) begin bad++; $display("FAIL post_rst_r5 got=%h want=0", m_rd(0)); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd3}; m_wr_data = {32'h0, 32'hA5A5A5A5}; m_rd_addr = {5'd0, 5'd3};
    n_wr_en = 1'b1;  n_wr_addr = 5'd3;         n_wr_data = 32'hA5A5A5A5;          n_rd_addr = {5'd0, 5'd3};
    #1;
    total++; if (m_rd(0) !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_same_cycle got=%h want=a5a5a5a5", m_rd(0)); end
    total++; if (n_rd(0) !== 32'h0) begin bad++; $display("FAIL nobyp_same_cycle got=%h want=0", n_rd(0)); end
    @(negedge clk);
    m_wr_en = '0; n_wr_en = '0;
    #1;
    total++; if (m_rd(0) !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_next_cycle got=%h want=a5a5a5a5", m_rd(0)); end
    total++; if (n_rd(0) !== 32'hA5A5A5A5) begin bad++; $display("FAIL nobyp_next_cycle got=%h want=a5a5a5a5", n_rd(0)); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    m_wr_en = 2'b01; m_wr_addr = '0; m_wr_data = {32'h0, 32'h1234}; m_iss_en = 1'b1; m_iss_addr = 5'd0; m_rd_addr = '0;
    n_wr_en = 1'b1;  n_wr_addr = '0; n_wr_data = 32'h1234;          n_iss_en = 1'b1; n_iss_addr = 5'd0; n_rd_addr = '0;
    #1;
    total++; if (m_rd(0) !== 32'h0) begin bad++; $display("FAIL zero_same_data got=%h want=0", m_rd(0)); end
    total++; if (m_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL zero_same_busy got=%b want=0", m_rd_busy[0]); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd(0) !== 32'h0) begin bad++; $display("FAIL zero_data got=%h want=0", m_rd(0)); end
    total++; if (m_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", m_rd_busy[0]); end
    total++; if (n_rd(0) !== 32'h1234) begin bad++; $display("FAIL nozero_data got=%h want=1234", n_rd(0)); end
    total++; if (n_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL nozero_busy got=%b want=1", n_rd_busy[0]); end
    @(negedge clk);
    n_wr_en = 1'b1; n_wr_addr = '0; n_wr_data = 32'h1234;
    @(negedge clk);
    idle_all();
    #1;
    total++; if (n_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL nozero_busy_clr got=%b want=0", n_rd_busy[0]); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    m_wr_en = 2'b11; m_wr_addr = {5'd7, 5'd7}; m_wr_data = {32'h22, 32'h11}; m_rd_addr = {5'd0, 5'd7};
    #1;
    total++; if (m_rd(0) !== 32'h22) begin bad++; $display("FAIL coll_bypass got=%h want=22", m_rd(0)); end
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL coll_conf_early got=%b want=0", m_conf); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd(0) !== 32'h22) begin bad++; $display("FAIL coll_r7 got=%h want=22", m_rd(0)); end
    total++; if (m_conf !== 1'b1) begin bad++; $display("FAIL coll_conf got=%b want=1", m_conf); end
    @(negedge clk);
    #1;
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL coll_conf_pulse got=%b want=0", m_conf); end
    m_wr_en = 2'b11; m_wr_addr = {5'd11, 5'd8}; m_wr_data = {32'h44, 32'h33};
    @(negedge clk);
    idle_all(); m_rd_addr = {5'd11, 5'd8};
    #1;
    total++; if (m_rd(0) !== 32'h33) begin bad++; $display("FAIL diff_r8 got=%h want=33", m_rd(0)); end
    total++; if (m_rd(1) !== 32'h44) begin bad++; $display("FAIL diff_r11 got=%h want=44", m_rd(1)); end
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL diff_conf got=%b want=0", m_conf); end
    m_wr_en = 2'b11; m_wr_addr = '0; m_wr_data = {32'h77, 32'h66};
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL zero_coll_conf got=%b want=0", m_conf); end
    m_wr_en = 2'b10; m_wr_addr = {5'd12, 5'd12}; m_wr_data = {32'h55, 32'h66}; m_rd_addr = {5'd0, 5'd12};
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd(0) !== 32'h55) begin bad++; $display("FAIL single_en_r12 got=%h want=55", m_rd(0)); end
    total++; if (m_conf !== 1'b0) begin bad++; $display("FAIL single_en_conf got=%b want=0", m_conf); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    m_iss_en = 1'b1; m_iss_addr = 5'd9; m_rd_addr = {5'd10, 5'd9};
    n_iss_en = 1'b1; n_iss_addr = 5'd9; n_rd_addr = {5'd10, 5'd9};
    #1;
    total++; if (m_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL iss_byp_busy got=%b want=1", m_rd_busy[0]); end
    total++; if (n_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL iss_nobyp_busy got=%b want=0", n_rd_busy[0]); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd_busy !== 2'b01) begin bad++; $display("FAIL iss_busy got=%b want=01", m_rd_busy); end
    total++; if (n_rd_busy !== 2'b01) begin bad++; $display("FAIL iss_n_busy got=%b want=01", n_rd_busy); end
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd9}; m_wr_data = {32'h0, 32'h99};
    #1;
    total++; if (m_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wb_byp_busy got=%b want=0", m_rd_busy[0]); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wb_busy got=%b want=0", m_rd_busy[0]); end
    total++; if (m_rd(0) !== 32'h99) begin bad++; $display("FAIL wb_data got=%h want=99", m_rd(0)); end
    m_iss_en = 1'b1; m_iss_addr = 5'd9;
    m_wr_en = 2'b01; m_wr_addr = {5'd0, 5'd9}; m_wr_data = {32'h0, 32'h9A};
    #1;
    total++; if (m_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL iss_wb_byp_busy got=%b want=1", m_rd_busy[0]); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL iss_wb_busy got=%b want=1", m_rd_busy[0]); end
    total++; if (m_rd(0) !== 32'h9A) begin bad++; $display("FAIL iss_wb_data got=%h want=9a", m_rd(0)); end
    m_iss_en = 1'b1; m_iss_addr = 5'd10; m_flush = 1'b1;
    n_flush = 1'b1;
    #1;
    total++; if (m_rd_busy !== 2'b00) begin bad++; $display("FAIL flush_byp_busy got=%b want=00", m_rd_busy); end
    total++; if (n_rd_busy !== 2'b01) begin bad++; $display("FAIL flush_nobyp_busy got=%b want=01", n_rd_busy); end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (m_rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b want=00", m_rd_busy); end
    total++; if (n_rd_busy !== 2'b00) begin bad++; $display("FAIL flush_n_busy got=%b want=00", n_rd_busy); end
    total++; if (m_rd(0) !== 32'h9A) begin bad++; $display("FAIL flush_keeps_data got=%h want=9a", m_rd(0)); end
  endtask

  task automatic test_wide();
    logic [63:0] ref_mem [64];
    logic [63:0] nxt [64];
    logic [5:0]  a0, a1, base, ra;
    logic [63:0] d0, d1;
    logic [1:0]  en;
    logic        exp_conf;
    exp_conf = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      en = 2'($urandom_range(0, 3));
      a0 = 6'($urandom_range(0, 63));
      a1 = (cyc % 5 == 0) ? a0 : 6'($urandom_range(0, 63));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      base = (cyc % 3 == 0) ? a0 : 6'($urandom_range(0, 63));
      w_wr_en = en; w_wr_addr = {a1, a0}; w_wr_data = {d1, d0};
      for (int i = 0; i < 4; i++) w_rd_addr[i*6 +: 6] = base + 6'(i * 16);
      for (int i = 0; i < 64; i++) nxt[i] = ref_mem[i];
      if (en[0] && a0 != 6'd0) nxt[a0] = d0;
      if (en[1] && a1 != 6'd0) nxt[a1] = d1;
      #1;
      for (int i = 0; i < 4; i++) begin
        ra = base + 6'(i * 16);
        total++; if (w_rd_data[i*64 +: 64] !== nxt[ra]) begin bad++; $display("FAIL wide_rd cyc=%0d p=%0d a=%0d got=%h want=%h", cyc, i, ra, w_rd_data[i*64 +: 64], nxt[ra]); end
      end
      total++; if (w_conf !== exp_conf) begin bad++; $display("FAIL wide_conf cyc=%0d got=%b want=%b", cyc, w_conf, exp_conf); end
      exp_conf = (en == 2'b11) && (a0 == a1) && (a0 != 6'd0);
      for (int i = 0; i < 64; i++) ref_mem[i] = nxt[i];
    end
    @(negedge clk);
    idle_all();
    #1;
    total++; if (w_conf !== exp_conf) begin bad++; $display("FAIL wide_conf_last got=%b want=%b", w_conf, exp_conf); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    idle_all();
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_iss_addr = '0;
    n_rd_addr = '0; n_wr_addr = '0; n_wr_data = '0; n_iss_addr = '0;
    w_rd_addr = '0; w_wr_addr = '0; w_wr_data = '0; w_iss_addr = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_conflict();
    test_scoreboard();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
